// File: rtl/pin_entry_pkg.sv
// Shared types and constants for the PIN entry block.
package pin_entry_pkg;

    localparam int PIN_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int COUNT_W    = 3;
    localparam int CODE_W     = PIN_DIGITS * DIGIT_W;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        FULL
    } state_e;

endpackage

// File: rtl/pin_entry_key_edge.sv
// Key conditioner: 2-flop synchronizer plus falling-edge detector, one press pulse per press.
module key_edge (
    input  logic clk,
    input  logic resetn,
    input  logic key_n_i,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic warm_q;
    logic armed_q;

    // The chain resets to "released"; armed_q only rises once the real key has been
    // seen high, so a key already held at reset release cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            warm_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            warm_q  <= 1'b1;
            armed_q <= armed_q | (warm_q & sync1_q);
        end
    end

    assign press_o = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/pin_entry.sv
// Four-digit PIN entry controller with debounced-free synchronized keys.
// Optional idle auto-clear enabled by defining PIN_ENTRY_TIMEOUT_EN.
module pin_entry
    import pin_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [DIGIT_W-1:0] sw,
    input  logic               key_enter,
    input  logic               key_submit,
    input  logic               key_clear,
    output logic [DIGIT_W-1:0] cin1,
    output logic [DIGIT_W-1:0] cin2,
    output logic [DIGIT_W-1:0] cin3,
    output logic [DIGIT_W-1:0] cin4,
    output logic [COUNT_W-1:0] count,
    output logic [CODE_W-1:0]  code,
    output logic               code_valid,
    output logic               err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic enter_p, submit_p, clear_p;

    key_edge u_enter  (.clk(clk), .resetn(resetn), .key_n_i(key_enter),  .press_o(enter_p));
    key_edge u_submit (.clk(clk), .resetn(resetn), .key_n_i(key_submit), .press_o(submit_p));
    key_edge u_clear  (.clk(clk), .resetn(resetn), .key_n_i(key_clear),  .press_o(clear_p));

    state_e                               state_q, state_d;
    logic [PIN_DIGITS-1:0][DIGIT_W-1:0]   digits_q, digits_d;
    logic [COUNT_W-1:0]                   count_q, count_d;
    logic [CODE_W-1:0]                    code_q, code_d;
    logic                                 code_valid_q, code_valid_d;
    logic                                 err_q, err_d;
    logic                                 do_clear;

`ifdef PIN_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout;
    assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            digits_q     <= '0;
            count_q      <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef PIN_ENTRY_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            digits_q     <= digits_d;
            count_q      <= count_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            err_q        <= err_d;
`ifdef PIN_ENTRY_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    // Clear outranks submit, which outranks enter; losers are dropped silently.
    always_comb begin
        state_d      = state_q;
        digits_d     = digits_q;
        count_d      = count_q;
        code_d       = '0;
        code_valid_d = 1'b0;
        err_d        = 1'b0;
        do_clear     = 1'b0;

        if (clear_p) begin
            do_clear = 1'b1;
        end else if (submit_p) begin
            if (state_q == FULL) begin
                code_d       = digits_q;
                code_valid_d = 1'b1;
                do_clear     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (enter_p) begin
            if (state_q == FULL || sw > MAX_DIGIT) begin
                err_d = 1'b1;
            end else begin
                digits_d = {digits_q[PIN_DIGITS-2:0], sw};
                count_d  = count_q + 3'd1;
                state_d  = (count_q == COUNT_W'(PIN_DIGITS - 1)) ? FULL : ENTRY;
            end
        end
`ifdef PIN_ENTRY_TIMEOUT_EN
        else if (timeout) begin
            do_clear = 1'b1;
            err_d    = 1'b1;
        end
`endif

        if (do_clear) begin
            state_d  = IDLE;
            digits_d = '0;
            count_d  = '0;
        end
    end

`ifdef PIN_ENTRY_TIMEOUT_EN
    always_comb begin
        timer_d = '0;
        if (!(enter_p | submit_p | clear_p) && state_q != IDLE && !timeout)
            timer_d = timer_q + 1'b1;
    end
`endif

    assign cin1       = digits_q[0];
    assign cin2       = digits_q[1];
    assign cin3       = digits_q[2];
    assign cin4       = digits_q[3];
    assign count      = count_q;
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign err        = err_q;

endmodule

// File: doc/pin_entry.md
PIN_ENTRY -- requirements
Module: pin_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000000, meaning idle clocks before auto-clear (used only with PIN_ENTRY_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port sw  input  4  digit value from switches, binary.
REQ-005 SHALL have port key_enter  input  1  raw push-button, active-low, asynchronous: load digit.
REQ-006 SHALL have port key_submit  input  1  raw push-button, active-low, asynchronous: submit code.
REQ-007 SHALL have port key_clear  input  1  raw push-button, active-low, asynchronous: discard entry.
REQ-008 SHALL have ports cin1, cin2, cin3, cin4  output  4 each  BCD digits for the display decoder; cin1 is newest.
REQ-009 SHALL have port count  output  3  digits held, 0..4.
REQ-010 SHALL have port code  output  16  {cin4,cin3,cin2,cin1}, valid when code_valid=1.
REQ-011 SHALL have port code_valid  output  1  one-cycle pulse on accepted submit.
REQ-012 SHALL have port err  output  1  one-cycle pulse on rejected action.

Function
REQ-013 SHALL pass each key through a 2-flop synchronizer, then a falling-edge detector, giving one press pulse per press.
REQ-014 SHALL act on the 3rd rising clk edge after a key input goes low and stays low; a held key SHALL yield only one action.
REQ-015 SHALL have states IDLE (count=0), ENTRY (count 1..3), FULL (count=4).
REQ-016 Enter press with sw<=9 in IDLE/ENTRY: cin4<=cin3, cin3<=cin2, cin2<=cin1, cin1<=sw, count+1; 3->4 moves to FULL.
REQ-017 Enter press with sw>9: no digit change, err pulse.
REQ-018 Enter press in FULL: ignored, err pulse.
REQ-019 Submit press in FULL: code_valid=1 and code=digits for exactly one cycle; next cycle all cin*=0, count=0, IDLE.
REQ-020 Submit press in IDLE/ENTRY: ignored, err pulse, digits kept.
REQ-021 Clear press: all cin*=0, count=0, IDLE, no err; legal in every state.
REQ-022 Priority for same-cycle presses: clear > submit > enter; lower-priority presses dropped without err.
REQ-023 code SHALL be 0 whenever code_valid=0.
REQ-024 Outputs cin*, count, code, code_valid, err SHALL be registered.

Reset
REQ-025 resetn=0 at a rising edge SHALL set cin1..cin4=0, count=0, code=0, code_valid=0, err=0, state IDLE, synchronizer flops=1 (released), timer=0.
REQ-026 Reset mid-entry or during code_valid SHALL discard the entry; no pulse after reset.
REQ-027 A key already held low at reset release SHALL NOT generate a press.

Configuration
REQ-028 Macro PIN_ENTRY_TIMEOUT_EN defined: counter resets on any press, increments in ENTRY/FULL; on reaching TIMEOUT_CYCLES-1 it SHALL clear as in REQ-021 and pulse err.
REQ-029 Macro undefined: no timer logic; entry persists indefinitely.

Structure
REQ-030 Shared package SHALL hold the state enum (IDLE, ENTRY, FULL), PIN_DIGITS=4, DIGIT_W=4, MAX_DIGIT=9.
REQ-031 Synchronizer plus edge detector SHALL be sub-module key_edge, instantiated three times.

Verification
REQ-032 Presses with sw=1,2,3,4 -> cin4..cin1=1,2,3,4, count=4; submit -> code=16'h1234, code_valid high 1 cycle, then all 0.
REQ-033 sw=4'hA, enter -> err 1 cycle, count unchanged; 5th enter in FULL -> err, digits unchanged.
REQ-034 Two digits then submit -> err, count=2; clear -> count=0, cin*=0.
REQ-035 Clear and submit in same cycle in FULL -> cleared, no code_valid, no err.
REQ-036 Key held low for 100 cycles -> exactly one digit loaded; resetn low mid-entry -> all outputs 0 next cycle.
REQ-037 With PIN_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: one digit, no presses for 16 cycles -> clear plus err pulse.
